// File: rtl/adc_frame_builder_if.sv
// Output word stream from the ADC frame builder to the USB FIFO writer.
// A word moves on a cycle where out_valid and out_ready are both high.
interface adc_frame_builder_if;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/adc_frame_builder.sv
// Gathers one 16-bit sample per ADC channel on each start and emits a frame
// (header, samples, status) with sticky per-channel error and timeout/overrun flags.
module adc_frame_builder #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [7:0]  HDR_TAG        = 8'hA5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_CH-1:0]    ch_valid,
  input  logic [16*NUM_CH-1:0] ch_data,
  input  logic [NUM_CH-1:0]    ch_error,
  adc_frame_builder_if.master  out_if,
  output logic                 busy,
  output logic [15:0]          frame_cnt,
  output logic [NUM_CH-1:0]    err_sticky,
  output logic                 err_any,
  output logic                 timeout_flag,
  output logic                 overrun_flag,
  input  logic                 err_clear
);

  localparam int IDXW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TCW  = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_HEADER,
    ST_DATA,
    ST_STATUS
  } state_t;

  state_t              r_state;
  logic [15:0]         r_buf [NUM_CH];
  logic [NUM_CH-1:0]   r_rcv;
  logic [NUM_CH-1:0]   r_ferr;
  logic [TCW-1:0]      r_tcnt;
  logic [IDXW-1:0]     r_idx;
  logic [15:0]         r_frame_cnt;
  logic [NUM_CH-1:0]   r_err_sticky;
  logic                r_timeout;
  logic                r_overrun;
  logic                r_busy;
  logic                r_out_valid;
  logic [15:0]         r_out_data;

  logic [NUM_CH-1:0]   w_cap;
  logic [NUM_CH-1:0]   w_rcv_next;
  logic                w_full;
  logic                w_tc_hit;
  logic                w_to_set;
  logic                w_xfer;
  logic                w_last;
  logic [IDXW-1:0]     w_sel;
  logic [15:0]         w_word;
  logic [7:0]          w_ferr8;
  logic [7:0]          w_miss8;

  // Full mask on the timeout cycle counts as complete, so w_to_set needs !w_full.
  always_comb begin
    w_cap      = (r_state == ST_COLLECT) ? (ch_valid & ~r_rcv) : '0;
    w_rcv_next = r_rcv | w_cap;
    w_full     = &w_rcv_next;
    w_tc_hit   = (r_tcnt == TCW'(TIMEOUT_CYCLES - 1));
    w_to_set   = (r_state == ST_COLLECT) && !w_full && w_tc_hit;
    w_xfer     = r_out_valid && out_if.out_ready;
    w_last     = (r_idx == IDXW'(NUM_CH - 1));
    w_sel      = (r_state == ST_HEADER) ? '0 : r_idx + 1'b1;
    w_word     = r_rcv[w_sel] ? r_buf[w_sel] : 16'hFFFF;
    w_ferr8    = '0;
    w_miss8    = '0;
    w_ferr8[NUM_CH-1:0] = r_ferr;
    w_miss8[NUM_CH-1:0] = ~r_rcv;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_rcv        <= '0;
      r_ferr       <= '0;
      r_tcnt       <= '0;
      r_idx        <= '0;
      r_frame_cnt  <= '0;
      r_err_sticky <= '0;
      r_timeout    <= 1'b0;
      r_overrun    <= 1'b0;
      r_busy       <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) r_buf[i] <= '0;
    end else begin
      r_err_sticky <= (err_clear ? '0 : r_err_sticky) | (w_cap & ch_error);
      r_timeout    <= (err_clear ? 1'b0 : r_timeout) | w_to_set;
      r_overrun    <= (err_clear ? 1'b0 : r_overrun) | (start && r_busy);

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_COLLECT;
            r_busy  <= 1'b1;
            r_rcv   <= '0;
            r_ferr  <= '0;
            r_tcnt  <= '0;
          end
        end
        ST_COLLECT: begin
          for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (w_cap[i]) begin
              r_buf[i]  <= ch_data[16*i +: 16];
              r_ferr[i] <= ch_error[i];
            end
          end
          r_rcv  <= w_rcv_next;
          r_tcnt <= r_tcnt + 1'b1;
          if (w_full || w_tc_hit) begin
            r_state     <= ST_HEADER;
            r_out_valid <= 1'b1;
            r_out_data  <= {HDR_TAG, r_frame_cnt[7:0]};
          end
        end
        ST_HEADER: begin
          if (w_xfer) begin
            r_state    <= ST_DATA;
            r_idx      <= '0;
            r_out_data <= w_word;
          end
        end
        ST_DATA: begin
          if (w_xfer) begin
            if (w_last) begin
              r_state    <= ST_STATUS;
              r_out_data <= {w_ferr8, w_miss8};
            end else begin
              r_idx      <= r_idx + 1'b1;
              r_out_data <= w_word;
            end
          end
        end
        ST_STATUS: begin
          if (w_xfer) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_frame_cnt <= r_frame_cnt + 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_busy      <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_if.out_data  = r_out_data;
  assign out_if.out_valid = r_out_valid;
  assign busy             = r_busy;
  assign frame_cnt        = r_frame_cnt;
  assign err_sticky       = r_err_sticky;
  assign err_any          = |r_err_sticky;
  assign timeout_flag     = r_timeout;
  assign overrun_flag     = r_overrun;

endmodule

// File: tb/tb_adc_frame_builder.sv
// Directed bench for adc_frame_builder (NUM_CH=4, TIMEOUT_CYCLES=16): expected
// frame words are queued as stimulus is driven and checked as words transfer.
module tb_adc_frame_builder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  ch_valid;
  logic [63:0] ch_data;
  logic [3:0]  ch_error;
  logic        busy;
  logic [15:0] frame_cnt;
  logic [3:0]  err_sticky;
  logic        err_any;
  logic        timeout_flag;
  logic        overrun_flag;
  logic        err_clear;

  adc_frame_builder_if u_if ();

  adc_frame_builder #(
    .NUM_CH         (4),
    .TIMEOUT_CYCLES (16),
    .HDR_TAG        (8'hA5)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .ch_valid     (ch_valid),
    .ch_data      (ch_data),
    .ch_error     (ch_error),
    .out_if       (u_if),
    .busy         (busy),
    .frame_cnt    (frame_cnt),
    .err_sticky   (err_sticky),
    .err_any      (err_any),
    .timeout_flag (timeout_flag),
    .overrun_flag (overrun_flag),
    .err_clear    (err_clear)
  );

  always #5 clk = ~clk;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [15:0] exp_q[$];
  logic        hold_pend = 1'b0;
  logic [15:0] hold_data = '0;

  // Transfer monitor: pops the scoreboard on each handshake and checks that a
  // stalled word stays put until it is accepted.
  always @(negedge clk) begin
    logic [15:0] exp_w;
    if (!reset) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        n_cmp++;
        assert (u_if.out_valid === 1'b1 && u_if.out_data === hold_data) else begin
          n_fail++;
          $error("FAIL hold_stable: observed valid=%0b data=%h expected valid=1 data=%h",
                 u_if.out_valid, u_if.out_data, hold_data);
        end
      end
      if (u_if.out_valid && u_if.out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL unexpected_word: observed %h expected no word", u_if.out_data);
          end
        end else begin
          exp_w = exp_q.pop_front();
          assert (u_if.out_data === exp_w) else begin
            n_fail++;
            $error("FAIL frame_word: observed %h expected %h", u_if.out_data, exp_w);
          end
        end
        hold_pend = 1'b0;
      end else if (u_if.out_valid) begin
        hold_pend = 1'b1;
        hold_data = u_if.out_data;
      end else begin
        hold_pend = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input int max_cyc);
    int k = 0;
    while (busy !== 1'b0 && k < max_cyc) begin
      step();
      k++;
    end
    chk("idle_reached", {31'd0, busy}, 32'd0);
    chk("queue_drained", exp_q.size(), 32'd0);
  endtask

  task automatic push_frame(input logic [15:0] w0, w1, w2, w3, w4, w5);
    exp_q.push_back(w0); exp_q.push_back(w1); exp_q.push_back(w2);
    exp_q.push_back(w3); exp_q.push_back(w4); exp_q.push_back(w5);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; ch_valid = '0; ch_data = '0; ch_error = '0;
    err_clear = 1'b0; u_if.out_ready = 1'b1;
    step(); step();
    chk("rst_out_valid", {31'd0, u_if.out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, u_if.out_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    chk("rst_flags", {26'd0, err_sticky, err_any, timeout_flag}, 32'd0);
    chk("rst_overrun", {31'd0, overrun_flag}, 32'd0);
    reset = 1'b1;
    step();

    // Frame 1: complete frame, all channels together
    push_frame(16'hA500, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h0000);
    start = 1'b1; step(); start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    step();
    ch_valid = 4'b1111; ch_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    step(); ch_valid = '0;
    wait_idle(40);
    chk("f1_frame_cnt", {16'd0, frame_cnt}, 32'd1);
    chk("f1_flags", {25'd0, err_sticky, err_any, timeout_flag, overrun_flag}, 32'd0);

    // Frame 2: channels 0/2 only -> timeout; ch1 strobe in start cycle ignored
    push_frame(16'hA501, 16'hAAAA, 16'hFFFF, 16'hBBBB, 16'hFFFF, 16'h000A);
    start = 1'b1; ch_valid = 4'b0010; ch_data = {16'h0, 16'h0, 16'hDEAD, 16'h0};
    step(); start = 1'b0;
    ch_valid = 4'b0101; ch_data = {16'h0, 16'hBBBB, 16'h0, 16'hAAAA};
    step(); ch_valid = '0;
    wait_idle(60);
    chk("f2_timeout_flag", {31'd0, timeout_flag}, 32'd1);
    chk("f2_frame_cnt", {16'd0, frame_cnt}, 32'd2);

    // Frame 3: ch2 error, out_ready toggling, then err_clear
    push_frame(16'hA502, 16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0400);
    start = 1'b1; step(); start = 1'b0;
    ch_valid = 4'b1111; ch_error = 4'b0100;
    ch_data = {16'h0404, 16'h0303, 16'h0202, 16'h0101};
    step(); ch_valid = '0; ch_error = '0;
    for (int k = 0; k < 60 && busy; k++) begin
      u_if.out_ready = ~u_if.out_ready;
      step();
    end
    u_if.out_ready = 1'b1;
    wait_idle(10);
    chk("f3_err_sticky", {28'd0, err_sticky}, 32'h4);
    chk("f3_err_any", {31'd0, err_any}, 32'd1);
    err_clear = 1'b1; step(); err_clear = 1'b0;
    chk("clr_flags", {25'd0, err_sticky, err_any, timeout_flag, overrun_flag}, 32'd0);

    // Frame 4: duplicate ch1 strobe ignored, start during DATA -> overrun
    push_frame(16'hA503, 16'h1010, 16'h5555, 16'h3030, 16'h4040, 16'h0000);
    start = 1'b1; step(); start = 1'b0;
    ch_valid = 4'b0011; ch_data = {16'h0, 16'h0, 16'h5555, 16'h1010};
    step();
    ch_valid = 4'b0010; ch_data = {16'h0, 16'h0, 16'h9999, 16'h0};
    step();
    ch_valid = 4'b1100; ch_data = {16'h4040, 16'h3030, 16'h0, 16'h0};
    step(); ch_valid = '0;
    step(); step();
    chk("f4_overrun_pre", {31'd0, overrun_flag}, 32'd0);
    start = 1'b1; step(); start = 1'b0;
    wait_idle(20);
    chk("f4_overrun_flag", {31'd0, overrun_flag}, 32'd1);
    repeat (6) step();
    chk("f4_no_second_frame", {31'd0, busy}, 32'd0);
    chk("f4_frame_cnt", {16'd0, frame_cnt}, 32'd4);

    // Frame 5: last channel arrives on the 16th COLLECT cycle -> complete
    push_frame(16'hA504, 16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D, 16'h0000);
    start = 1'b1; step(); start = 1'b0;
    ch_valid = 4'b0111; ch_data = {16'h0, 16'h0C0C, 16'h0B0B, 16'h0A0A};
    step(); ch_valid = '0;
    repeat (14) step();
    ch_valid = 4'b1000; ch_data = {16'h0D0D, 16'h0, 16'h0, 16'h0};
    step(); ch_valid = '0;
    wait_idle(20);
    chk("f5_timeout_flag", {31'd0, timeout_flag}, 32'd0);
    chk("f5_frame_cnt", {16'd0, frame_cnt}, 32'd5);

    // Frame 6: reset during DATA(1) discards the frame
    exp_q.push_back(16'hA505); exp_q.push_back(16'h1111);
    start = 1'b1; step(); start = 1'b0;
    ch_valid = 4'b1111; ch_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    step(); ch_valid = '0;
    step(); step();
    reset = 1'b0; u_if.out_ready = 1'b0;
    step();
    reset = 1'b1;
    chk("rst_mid_out_valid", {31'd0, u_if.out_valid}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    chk("rst_mid_queue", exp_q.size(), 32'd0);
    u_if.out_ready = 1'b1;
    step();
    push_frame(16'hA500, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h0000);
    start = 1'b1; step(); start = 1'b0;
    ch_valid = 4'b1111;
    step(); ch_valid = '0;
    wait_idle(40);
    chk("f7_frame_cnt", {16'd0, frame_cnt}, 32'd1);

    repeat (4) step();
    chk("final_queue", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
